// File: rtl/buffer_read_pkg.sv
// Shared types and constants for the banked block read path.
// Word g of a block lives in bank g mod bank_count at address g div bank_count.
package buffer_read_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } read_state_t;

    localparam int FIFO_DEPTH  = 4;
    localparam int RAM_LATENCY = 1;

    function automatic int bank_of(input int g, input int bank_count);
        return g % bank_count;
    endfunction

    function automatic int row_of(input int g, input int bank_count);
        return g / bank_count;
    endfunction

endpackage

// File: rtl/buffer_read_fifo.sv
// Small synchronous FIFO with first-word fall-through and an occupancy count.
// Write and read may happen in the same cycle.
module buffer_read_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/buffer_read_sequencer.sv
// Streams a block held across interleaved RAM banks out in global word order,
// issuing one bank read per cycle only while the output FIFO has room for it.
module buffer_read_sequencer
    import buffer_read_pkg::*;
#(
    parameter int BANK_COUNT  = 3,
    parameter int BLOCK_DEPTH = 480,
    parameter int DATA_WIDTH  = 24,
    localparam int ADDR_W     = $clog2(BLOCK_DEPTH),
    localparam int LEN_W      = $clog2(BANK_COUNT * BLOCK_DEPTH + 1)
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_start,
    input  logic [LEN_W-1:0]      I_length,
    output logic                  O_busy,
    output logic                  O_done,
    output logic [BANK_COUNT-1:0] O_bank_read_enable,
    output logic [ADDR_W-1:0]     O_bank_address [0:BANK_COUNT-1],
    input  logic [DATA_WIDTH-1:0] I_bank_data [0:BANK_COUNT-1],
    output logic [DATA_WIDTH-1:0] O_data,
    output logic                  O_valid,
    input  logic                  I_ready
);

    localparam int TOTAL_WORDS = BANK_COUNT * BLOCK_DEPTH;
    localparam int BSEL_W      = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
    localparam int PIPE_STAGES = RAM_LATENCY + 1;
    localparam int FCNT_W      = $clog2(FIFO_DEPTH + 1);

    read_state_t state_q, state_d;

    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       len_clamped;
    logic [LEN_W-1:0]       issued_q;
    logic [BSEL_W-1:0]      bank_sel_q;
    logic [ADDR_W-1:0]      row_q;
    logic                   done_q;
    logic                   done_d;

    logic                   issue_fire;
    logic [BSEL_W-1:0]      issue_bank;
    logic [ADDR_W-1:0]      issue_row;
    logic [LEN_W-1:0]       issue_idx;
    logic                   credit;

    logic [PIPE_STAGES-1:0] pipe_v;
    logic [BSEL_W-1:0]      pipe_sel [PIPE_STAGES];
    logic [FCNT_W-1:0]      fifo_count;
    logic                   pop;

    assign len_clamped = (I_length > LEN_W'(TOTAL_WORDS)) ? LEN_W'(TOTAL_WORDS) : I_length;
    // Every word in flight already owns a FIFO slot, so the FIFO can never overflow.
    assign credit  = (int'(fifo_count) + $countones(pipe_v)) < FIFO_DEPTH;
    assign pop     = O_valid && I_ready;
    assign O_valid = (fifo_count != '0);
    assign O_busy  = (state_q != IDLE);
    assign O_done  = done_q;

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        issue_fire = 1'b0;
        issue_bank = bank_sel_q;
        issue_row  = row_q;
        issue_idx  = issued_q;
        case (state_q)
            IDLE: begin
                issue_bank = '0;
                issue_row  = '0;
                issue_idx  = '0;
                if (I_start) begin
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        issue_fire = 1'b1;
                        state_d    = (len_clamped == LEN_W'(1)) ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                if (credit) begin
                    issue_fire = 1'b1;
                    if (issued_q + LEN_W'(1) == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((pipe_v == '0) &&
                    ((fifo_count == '0) || ((fifo_count == FCNT_W'(1)) && pop))) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            len_q              <= '0;
            issued_q           <= '0;
            bank_sel_q         <= '0;
            row_q              <= '0;
            done_q             <= 1'b0;
            pipe_v             <= '0;
            O_bank_read_enable <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) pipe_sel[i] <= '0;
            for (int b = 0; b < BANK_COUNT; b++) O_bank_address[b] <= '0;
        end else begin
            done_q      <= done_d;
            pipe_v      <= {pipe_v[PIPE_STAGES-2:0], issue_fire};
            pipe_sel[0] <= issue_bank;
            for (int i = 1; i < PIPE_STAGES; i++) pipe_sel[i] <= pipe_sel[i-1];
            if (state_q == IDLE && I_start) len_q <= len_clamped;
            O_bank_read_enable <= '0;
            if (issue_fire) begin
                O_bank_read_enable[issue_bank] <= 1'b1;
                O_bank_address[issue_bank]     <= issue_row;
                issued_q                       <= issue_idx + LEN_W'(1);
                if (issue_bank == BSEL_W'(BANK_COUNT - 1)) begin
                    bank_sel_q <= '0;
                    row_q      <= issue_row + ADDR_W'(1);
                end else begin
                    bank_sel_q <= issue_bank + BSEL_W'(1);
                    row_q      <= issue_row;
                end
            end
        end
    end

    buffer_read_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys   (I_clk),
        .rst       (I_rst),
        .push      (pipe_v[PIPE_STAGES-1]),
        .push_data (I_bank_data[pipe_sel[PIPE_STAGES-1]]),
        .pop       (pop),
        .head      (O_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_buffer_read_sequencer.sv
// Scoreboard bench: expected words come from the global-word-to-bank mapping;
// a negedge monitor checks the stream, read strobes, busy/done and reset.
module tb_buffer_read_sequencer;

    localparam int BANK_COUNT  = 3;
    localparam int BLOCK_DEPTH = 480;
    localparam int DATA_WIDTH  = 24;
    localparam int ADDR_W      = 9;
    localparam int LEN_W       = 11;
    localparam int TOTAL       = BANK_COUNT * BLOCK_DEPTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [LEN_W-1:0]      length;
    logic                  busy;
    logic                  done;
    logic [BANK_COUNT-1:0] en;
    logic [ADDR_W-1:0]     addr [0:BANK_COUNT-1];
    logic [DATA_WIDTH-1:0] bank_data [0:BANK_COUNT-1];
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    always #5 clk = ~clk;

    buffer_read_sequencer #(
        .BANK_COUNT  (BANK_COUNT),
        .BLOCK_DEPTH (BLOCK_DEPTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) dut (
        .I_clk              (clk),
        .I_rst              (rst),
        .I_start            (start),
        .I_length           (length),
        .O_busy             (busy),
        .O_done             (done),
        .O_bank_read_enable (en),
        .O_bank_address     (addr),
        .I_bank_data        (bank_data),
        .O_data             (data),
        .O_valid            (valid),
        .I_ready            (ready)
    );

    // Banks preloaded with {bank, address}, one cycle read latency.
    always @(posedge clk) begin
        for (int b = 0; b < BANK_COUNT; b++)
            if (en[b]) bank_data[b] <= {8'(b), 16'(addr[b])};
    end

    int total = 0;
    int bad   = 0;

    logic [DATA_WIDTH-1:0] exp_q [$];
    bit  busy_due = 0, done_due = 0, rst_check = 0, prev_stall = 0, first_valid_seen = 0;
    int  since = 0, issue_idx = 0, run_len = 0, xfers_run = 0, ready_kind = 0, done_seen = 0;
    logic [DATA_WIDTH-1:0] prev_data;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit cur_busy;
        int bank, row, len;
        logic [DATA_WIDTH-1:0] e;
        since++;
        cur_busy = busy_due;
        check("done", done, done_due);
        check("busy", busy, busy_due);
        if (rst_check) begin
            check("rst_valid", valid, 0);
            check("rst_en", en, 0);
            check("rst_data", data, 0);
            check("rst_addr", {addr[0], addr[1], addr[2]}, 0);
        end
        rst_check = 0;
        if (done) done_seen++;
        done_due = 0;
        if (rst) begin
            exp_q.delete();
            busy_due   = 0;
            rst_check  = 1;
            prev_stall = 0;
        end else begin
            if (en != '0) begin
                check("en_onehot", $countones(en), 1);
                check("issue_in_range", longint'(issue_idx < run_len), 1);
                bank = issue_idx % BANK_COUNT;
                row  = issue_idx / BANK_COUNT;
                check("en_bank", en, longint'(1) << bank);
                check("en_addr", addr[bank], row);
                if (issue_idx == 0) check("first_en_cycle", since, 1);
                issue_idx++;
                check("credit", longint'(issue_idx - xfers_run <= 4), 1);
            end
            if (prev_stall) begin
                check("stall_valid", valid, 1);
                check("stall_data", data, prev_data);
            end
            if (ready_kind == 0 && cur_busy && since >= 3 && since <= run_len + 2)
                check("no_bubble", valid, 1);
            if (valid && cur_busy && !first_valid_seen) begin
                check("first_valid_cycle", since, 3);
                first_valid_seen = 1;
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected none (t=%0t)", data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("data", data, e);
                    xfers_run++;
                    if (exp_q.size() == 0) begin
                        done_due = 1;
                        busy_due = 0;
                    end
                end
            end
            prev_stall = valid && !ready;
            prev_data  = data;
            if (start && !cur_busy) begin
                len       = (int'(length) > TOTAL) ? TOTAL : int'(length);
                run_len   = len;
                issue_idx = 0;
                if (len == 0) begin
                    done_due = 1;
                end else begin
                    busy_due         = 1;
                    xfers_run        = 0;
                    first_valid_seen = 0;
                    since            = 0;
                    for (int g = 0; g < len; g++)
                        exp_q.push_back({8'(g % BANK_COUNT), 16'(g / BANK_COUNT)});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_at(input int kind, input int c);
        if (kind == 1) return ($urandom_range(0, 3) != 0);
        if (kind == 2) return !(c >= 4 && c <= 13);
        return 1'b1;
    endfunction

    task automatic run(input int len, input int kind, input bit poke_busy);
        int  seen0;
        bit  ok;
        seen0      = done_seen;
        ok         = 0;
        ready_kind = kind;
        start      = 1'b1;
        length     = LEN_W'(len);
        ready      = ready_at(kind, 0);
        for (int c = 1; c < 6000; c++) begin
            tick();
            start = poke_busy && (c == 4);
            if (c == 4) length = LEN_W'(5);
            ready = ready_at(kind, c);
            if (done_seen != seen0) begin
                ok = 1;
                break;
            end
        end
        check("run_timeout", ok, 1);
        start = 1'b0;
        ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        bit ok;
        rst    = 1'b1;
        start  = 1'b0;
        length = '0;
        ready  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        ready = 1'b1;
        tick();

        run(7, 0, 0);
        run(20, 2, 0);
        run(0, 0, 0);
        run(1, 0, 0);
        run(10, 0, 1);
        run(1440, 0, 0);
        run(2000, 1, 0);
        for (int i = 0; i < 6; i++) run($urandom_range(1, 60), 1, 0);

        ready_kind = 0;
        start  = 1'b1;
        length = LEN_W'(20);
        ready  = 1'b1;
        ok     = 0;
        for (int c = 1; c < 200; c++) begin
            tick();
            start = 1'b0;
            if (xfers_run >= 5) begin
                ok = 1;
                break;
            end
        end
        check("reset_wait_timeout", ok, 1);
        rst   = 1'b1;
        ready = 1'b0;
        tick();
        rst   = 1'b0;
        ready = 1'b1;
        repeat (6) tick();
        run(3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
